// File: rtl/mfp_ahb_gpio_multi_pkg.sv
// Shared register map, address field positions and size limits for the multi-channel GPIO slave.
// Optional input debounce is enabled with the MFP_GPIO_DEBOUNCE_EN macro.
package mfp_ahb_gpio_multi_pkg;

    typedef enum logic [2:0] {
        MFP_GPIO_REG_IN      = 3'd0,
        MFP_GPIO_REG_OUT     = 3'd1,
        MFP_GPIO_REG_DIR     = 3'd2,
        MFP_GPIO_REG_SET     = 3'd3,
        MFP_GPIO_REG_CLR     = 3'd4,
        MFP_GPIO_REG_IRQ_EN  = 3'd5,
        MFP_GPIO_REG_IRQ_POL = 3'd6,
        MFP_GPIO_REG_STAT    = 3'd7
    } gpioReg_e;

    localparam int ADDR_REG_LSB = 2;
    localparam int ADDR_REG_MSB = 4;
    localparam int ADDR_CH_LSB  = 5;
    localparam int ADDR_CH_MSB  = 7;

    localparam int MIN_CH    = 1;
    localparam int MAX_CH    = 8;
    localparam int MIN_WIDTH = 1;
    localparam int MAX_WIDTH = 32;

    localparam logic [1:0] HTRANS_IDLE = 2'b00;

    function automatic logic isWriteOnly(gpioReg_e rg);
        return (rg == MFP_GPIO_REG_SET) || (rg == MFP_GPIO_REG_CLR);
    endfunction

endpackage

// File: rtl/mfp_gpio_channel.sv
// One GPIO channel: control/status registers, input synchroniser, optional debounce filter
// (MFP_GPIO_DEBOUNCE_EN), edge detection and this channel's interrupt contribution.
module mfp_gpio_channel
    import mfp_ahb_gpio_multi_pkg::*;
#(
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef MFP_GPIO_DEBOUNCE_EN
    input  logic             tick_i,
`endif
    input  logic             wrEn_i,
    input  gpioReg_e         wrReg_i,
    input  logic [WIDTH-1:0] wrData_i,
    input  logic [WIDTH-1:0] pins_i,
    output logic [WIDTH-1:0] in_o,
    output logic [WIDTH-1:0] out_o,
    output logic [WIDTH-1:0] dir_o,
    output logic [WIDTH-1:0] irqEn_o,
    output logic [WIDTH-1:0] irqPol_o,
    output logic [WIDTH-1:0] stat_o,
    output logic             irq_o
);

    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] irqEn_q, irqEn_d;
    logic [WIDTH-1:0] irqPol_q, irqPol_d;
    logic [WIDTH-1:0] stat_q, stat_d;
    logic [WIDTH-1:0] sync1_q, sync2_q, prev_q;
    logic [WIDTH-1:0] filt;
    logic [WIDTH-1:0] rise, fall, setBits, clrBits;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= pins_i;
            sync2_q <= sync1_q;
            prev_q  <= filt;
        end
    end

`ifdef MFP_GPIO_DEBOUNCE_EN
    // A bit only moves once two consecutive tick samples agree on its new level.
    logic [WIDTH-1:0] sample_q, filt_q, agree;

    assign agree = ~(sync2_q ^ sample_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_q <= '0;
            filt_q   <= '0;
        end else if (tick_i) begin
            sample_q <= sync2_q;
            filt_q   <= (sync2_q & agree) | (filt_q & ~agree);
        end
    end

    assign filt = filt_q;
`else
    assign filt = sync2_q;
`endif

    assign rise    = filt & ~prev_q;
    assign fall    = ~filt & prev_q;
    assign setBits = ((irqPol_q & rise) | (~irqPol_q & fall)) & irqEn_q;
    assign clrBits = (wrEn_i && wrReg_i == MFP_GPIO_REG_STAT) ? wrData_i : '0;

    always_comb begin
        out_d    = out_q;
        dir_d    = dir_q;
        irqEn_d  = irqEn_q;
        irqPol_d = irqPol_q;
        // A status bit being set in the same cycle it is cleared stays set.
        stat_d   = (stat_q & ~clrBits) | setBits;
        if (wrEn_i) begin
            case (wrReg_i)
                MFP_GPIO_REG_OUT:     out_d    = wrData_i;
                MFP_GPIO_REG_DIR:     dir_d    = wrData_i;
                MFP_GPIO_REG_SET:     out_d    = out_q | wrData_i;
                MFP_GPIO_REG_CLR:     out_d    = out_q & ~wrData_i;
                MFP_GPIO_REG_IRQ_EN:  irqEn_d  = wrData_i;
                MFP_GPIO_REG_IRQ_POL: irqPol_d = wrData_i;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q    <= '0;
            dir_q    <= '0;
            irqEn_q  <= '0;
            irqPol_q <= '0;
            stat_q   <= '0;
        end else begin
            out_q    <= out_d;
            dir_q    <= dir_d;
            irqEn_q  <= irqEn_d;
            irqPol_q <= irqPol_d;
            stat_q   <= stat_d;
        end
    end

    assign in_o     = filt;
    assign out_o    = out_q;
    assign dir_o    = dir_q;
    assign irqEn_o  = irqEn_q;
    assign irqPol_o = irqPol_q;
    assign stat_o   = stat_q;
    assign irq_o    = |(stat_q & irqEn_q);

endmodule

// File: rtl/mfp_ahb_gpio_multi.sv
// Zero-wait-state AHB-Lite slave fronting NUM_CH GPIO channels with one combined interrupt.
// Defining MFP_GPIO_DEBOUNCE_EN adds a shared debounce prescaler and per-bit input filters.
module mfp_ahb_gpio_multi
    import mfp_ahb_gpio_multi_pkg::*;
#(
    parameter int NUM_CH          = 2,
    parameter int WIDTH           = 18,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    input  logic [31:0]             HADDR,
    input  logic [2:0]              HBURST,
    input  logic                    HMASTLOCK,
    input  logic [3:0]              HPROT,
    input  logic [2:0]              HSIZE,
    input  logic                    HSEL,
    input  logic [1:0]              HTRANS,
    input  logic                    HWRITE,
    input  logic [31:0]             HWDATA,
    output logic [31:0]             HRDATA,
    output logic                    HREADY,
    output logic                    HRESP,
    input  logic                    SI_Endian,
    input  logic [NUM_CH*WIDTH-1:0] GPIO_In,
    output logic [NUM_CH*WIDTH-1:0] GPIO_Out,
    output logic [NUM_CH*WIDTH-1:0] GPIO_Oe,
    output logic                    GPIO_Irq
);

    logic       valid_q, write_q;
    logic [2:0] addrCh_q;
    gpioReg_e   addrReg_q;
    logic       irq_q;

    logic [WIDTH-1:0] chIn     [NUM_CH];
    logic [WIDTH-1:0] chOut    [NUM_CH];
    logic [WIDTH-1:0] chDir    [NUM_CH];
    logic [WIDTH-1:0] chIrqEn  [NUM_CH];
    logic [WIDTH-1:0] chIrqPol [NUM_CH];
    logic [WIDTH-1:0] chStat   [NUM_CH];
    logic [NUM_CH-1:0] chIrq;
    logic [31:0]       rdata;
    logic              unusedInputs;

    assign unusedInputs = ^{HADDR[31:ADDR_CH_MSB+1], HADDR[ADDR_REG_LSB-1:0], HBURST,
                            HMASTLOCK, HPROT, HSIZE, SI_Endian, HWDATA};

    // HREADY is tied high, so every cycle closes an address phase.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            valid_q   <= 1'b0;
            write_q   <= 1'b0;
            addrCh_q  <= '0;
            addrReg_q <= MFP_GPIO_REG_IN;
        end else begin
            valid_q   <= HSEL && (HTRANS != HTRANS_IDLE);
            write_q   <= HWRITE;
            addrCh_q  <= HADDR[ADDR_CH_MSB:ADDR_CH_LSB];
            addrReg_q <= gpioReg_e'(HADDR[ADDR_REG_MSB:ADDR_REG_LSB]);
        end
    end

`ifdef MFP_GPIO_DEBOUNCE_EN
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    logic [CNT_W-1:0] preCnt_q;
    logic             tick;

    assign tick = (preCnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            preCnt_q <= '0;
        end else if (tick) begin
            preCnt_q <= '0;
        end else begin
            preCnt_q <= preCnt_q + 1'b1;
        end
    end
`else
    localparam int unusedDebounce = DEBOUNCE_CYCLES;
`endif

    for (genvar c = 0; c < NUM_CH; c++) begin : gChan
        logic wrEn;

        assign wrEn = valid_q && write_q && (addrCh_q == 3'(c));

        mfp_gpio_channel #(
            .WIDTH(WIDTH)
        ) uChan (
            .clk      (HCLK),
            .rst_n    (HRESETn),
`ifdef MFP_GPIO_DEBOUNCE_EN
            .tick_i   (tick),
`endif
            .wrEn_i   (wrEn),
            .wrReg_i  (addrReg_q),
            .wrData_i (HWDATA[WIDTH-1:0]),
            .pins_i   (GPIO_In[c*WIDTH +: WIDTH]),
            .in_o     (chIn[c]),
            .out_o    (chOut[c]),
            .dir_o    (chDir[c]),
            .irqEn_o  (chIrqEn[c]),
            .irqPol_o (chIrqPol[c]),
            .stat_o   (chStat[c]),
            .irq_o    (chIrq[c])
        );

        assign GPIO_Out[c*WIDTH +: WIDTH] = chOut[c];
        assign GPIO_Oe[c*WIDTH +: WIDTH]  = chDir[c];
    end

    // Channels beyond NUM_CH match no loop iteration and read back zero.
    always_comb begin
        rdata = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (addrCh_q == 3'(c) && !isWriteOnly(addrReg_q)) begin
                case (addrReg_q)
                    MFP_GPIO_REG_IN:      rdata = 32'(chIn[c]);
                    MFP_GPIO_REG_OUT:     rdata = 32'(chOut[c]);
                    MFP_GPIO_REG_DIR:     rdata = 32'(chDir[c]);
                    MFP_GPIO_REG_IRQ_EN:  rdata = 32'(chIrqEn[c]);
                    MFP_GPIO_REG_IRQ_POL: rdata = 32'(chIrqPol[c]);
                    MFP_GPIO_REG_STAT:    rdata = 32'(chStat[c]);
                    default:              rdata = '0;
                endcase
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |chIrq;
        end
    end

    assign HRDATA   = rdata;
    assign HREADY   = 1'b1;
    assign HRESP    = 1'b0;
    assign GPIO_Irq = irq_q;

endmodule

// File: tb/tb_mfp_ahb_gpio_multi.sv
// Directed, table-driven bench for mfp_ahb_gpio_multi (2 channels x 18 bits, debounce period 4).
// Build with MFP_GPIO_DEBOUNCE_EN defined to exercise the glitch filter instead of exact edge timing.
module tb_mfp_ahb_gpio_multi;

    localparam int NUM_CH = 2;
    localparam int WIDTH  = 18;
    localparam int NPINS  = NUM_CH * WIDTH;

    localparam logic [2:0] R_IN = 3'd0, R_OUT = 3'd1, R_DIR = 3'd2, R_SET = 3'd3;
    localparam logic [2:0] R_CLR = 3'd4, R_EN = 3'd5, R_POL = 3'd6, R_STAT = 3'd7;

    typedef struct {
        bit          isWrite;
        logic [2:0]  ch;
        logic [2:0]  rg;
        logic [31:0] data;
        logic [NPINS-1:0] expOut;
        logic [NPINS-1:0] expOe;
    } vec_t;

    logic             HCLK = 1'b0;
    logic             HRESETn;
    logic [31:0]      HADDR;
    logic [2:0]       HBURST;
    logic             HMASTLOCK;
    logic [3:0]       HPROT;
    logic [2:0]       HSIZE;
    logic             HSEL;
    logic [1:0]       HTRANS;
    logic             HWRITE;
    logic [31:0]      HWDATA;
    logic [31:0]      HRDATA;
    logic             HREADY;
    logic             HRESP;
    logic             SI_Endian;
    logic [NPINS-1:0] GPIO_In;
    logic [NPINS-1:0] GPIO_Out;
    logic [NPINS-1:0] GPIO_Oe;
    logic             GPIO_Irq;

    int errors = 0;
    int checks = 0;
    vec_t vecs [22];
    logic [31:0] rd;

    always #5 HCLK = ~HCLK;

    mfp_ahb_gpio_multi #(
        .NUM_CH(NUM_CH),
        .WIDTH(WIDTH),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HBURST(HBURST),
        .HMASTLOCK(HMASTLOCK), .HPROT(HPROT), .HSIZE(HSIZE), .HSEL(HSEL),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HWDATA(HWDATA), .HRDATA(HRDATA),
        .HREADY(HREADY), .HRESP(HRESP), .SI_Endian(SI_Endian), .GPIO_In(GPIO_In),
        .GPIO_Out(GPIO_Out), .GPIO_Oe(GPIO_Oe), .GPIO_Irq(GPIO_Irq)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] regAddr(input logic [2:0] ch, input logic [2:0] rg);
        return {24'h0, ch, rg, 2'b00};
    endfunction

    task automatic busIdle();
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HWRITE = 1'b0;
    endtask

    task automatic busWrite(input logic [2:0] ch, input logic [2:0] rg, input logic [31:0] data);
        @(posedge HCLK); #1;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = regAddr(ch, rg);
        @(posedge HCLK); #1;
        HWDATA = data;
        busIdle();
    endtask

    task automatic busRead(input logic [2:0] ch, input logic [2:0] rg, output logic [31:0] data);
        @(posedge HCLK); #1;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = regAddr(ch, rg);
        @(posedge HCLK); #1;
        busIdle();
        data = HRDATA;
    endtask

    task automatic applyStimulus(input int idx);
        if (vecs[idx].isWrite) begin
            busWrite(vecs[idx].ch, vecs[idx].rg, vecs[idx].data);
            @(posedge HCLK); #1;
        end else begin
            busRead(vecs[idx].ch, vecs[idx].rg, rd);
            checkOutput($sformatf("vec%0d_rdata", idx), 64'(rd), 64'(vecs[idx].data));
        end
        checkOutput($sformatf("vec%0d_out", idx), 64'(GPIO_Out), 64'(vecs[idx].expOut));
        checkOutput($sformatf("vec%0d_oe", idx), 64'(GPIO_Oe), 64'(vecs[idx].expOe));
    endtask

    initial begin
        HRESETn = 1'b0; HADDR = '0; HBURST = '0; HMASTLOCK = 1'b0; HPROT = '0; HSIZE = 3'b010;
        HWDATA = '0; SI_Endian = 1'b0; GPIO_In = '0;
        busIdle();

        vecs[0]  = '{1'b1, 3'd0, R_OUT,  32'h0003FFFF, {18'h0, 18'h3FFFF}, {18'h0, 18'h0}};
        vecs[1]  = '{1'b1, 3'd0, R_CLR,  32'h00000F0F, {18'h0, 18'h3F0F0}, {18'h0, 18'h0}};
        vecs[2]  = '{1'b1, 3'd0, R_SET,  32'h00000003, {18'h0, 18'h3F0F3}, {18'h0, 18'h0}};
        vecs[3]  = '{1'b0, 3'd0, R_OUT,  32'h0003F0F3, {18'h0, 18'h3F0F3}, {18'h0, 18'h0}};
        vecs[4]  = '{1'b0, 3'd0, R_SET,  32'h00000000, {18'h0, 18'h3F0F3}, {18'h0, 18'h0}};
        vecs[5]  = '{1'b0, 3'd0, R_CLR,  32'h00000000, {18'h0, 18'h3F0F3}, {18'h0, 18'h0}};
        vecs[6]  = '{1'b1, 3'd0, R_DIR,  32'h000155AA, {18'h0, 18'h3F0F3}, {18'h0, 18'h155AA}};
        vecs[7]  = '{1'b0, 3'd0, R_DIR,  32'h000155AA, {18'h0, 18'h3F0F3}, {18'h0, 18'h155AA}};
        vecs[8]  = '{1'b1, 3'd1, R_OUT,  32'hFFFFFFFF, {18'h3FFFF, 18'h3F0F3}, {18'h0, 18'h155AA}};
        vecs[9]  = '{1'b0, 3'd1, R_OUT,  32'h0003FFFF, {18'h3FFFF, 18'h3F0F3}, {18'h0, 18'h155AA}};
        vecs[10] = '{1'b1, 3'd5, R_OUT,  32'h00001234, {18'h3FFFF, 18'h3F0F3}, {18'h0, 18'h155AA}};
        vecs[11] = '{1'b0, 3'd5, R_OUT,  32'h00000000, {18'h3FFFF, 18'h3F0F3}, {18'h0, 18'h155AA}};
        vecs[12] = '{1'b0, 3'd0, R_OUT,  32'h0003F0F3, {18'h3FFFF, 18'h3F0F3}, {18'h0, 18'h155AA}};
        vecs[13] = '{1'b1, 3'd1, R_CLR,  32'h0002AAAA, {18'h15555, 18'h3F0F3}, {18'h0, 18'h155AA}};
        vecs[14] = '{1'b1, 3'd1, R_SET,  32'h00000008, {18'h1555D, 18'h3F0F3}, {18'h0, 18'h155AA}};
        vecs[15] = '{1'b0, 3'd1, R_OUT,  32'h0001555D, {18'h1555D, 18'h3F0F3}, {18'h0, 18'h155AA}};
        vecs[16] = '{1'b1, 3'd1, R_DIR,  32'h00000001, {18'h1555D, 18'h3F0F3}, {18'h1, 18'h155AA}};
        vecs[17] = '{1'b1, 3'd1, R_POL,  32'h0002AAAA, {18'h1555D, 18'h3F0F3}, {18'h1, 18'h155AA}};
        vecs[18] = '{1'b0, 3'd1, R_POL,  32'h0002AAAA, {18'h1555D, 18'h3F0F3}, {18'h1, 18'h155AA}};
        vecs[19] = '{1'b1, 3'd1, R_POL,  32'h00000000, {18'h1555D, 18'h3F0F3}, {18'h1, 18'h155AA}};
        vecs[20] = '{1'b0, 3'd7, R_STAT, 32'h00000000, {18'h1555D, 18'h3F0F3}, {18'h1, 18'h155AA}};
        vecs[21] = '{1'b0, 3'd1, R_EN,   32'h00000000, {18'h1555D, 18'h3F0F3}, {18'h1, 18'h155AA}};

        repeat (3) @(posedge HCLK);
        #1 HRESETn = 1'b1;
        checkOutput("reset_out", 64'(GPIO_Out), 64'h0);
        checkOutput("reset_oe", 64'(GPIO_Oe), 64'h0);
        checkOutput("reset_irq", 64'(GPIO_Irq), 64'h0);
        checkOutput("hready", 64'(HREADY), 64'h1);
        checkOutput("hresp", 64'(HRESP), 64'h0);

        for (int c = 0; c < NUM_CH; c++) begin
            for (int r = 0; r < 8; r++) begin
                busRead(3'(c), 3'(r), rd);
                checkOutput($sformatf("reset_rd_ch%0d_r%0d", c, r), 64'(rd), 64'h0);
            end
        end

        for (int i = 0; i < 22; i++) applyStimulus(i);

        // Write then read of the same register in the very next cycle.
        @(posedge HCLK); #1;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = regAddr(3'd0, R_OUT);
        @(posedge HCLK); #1;
        HWDATA = 32'h00012345; HWRITE = 1'b0;
        @(posedge HCLK); #1;
        busIdle();
        checkOutput("b2b_rdata", 64'(HRDATA), 64'h12345);
        checkOutput("b2b_out", 64'(GPIO_Out[17:0]), 64'h12345);

        // IN follows the pins even where DIR marks bits as outputs.
        GPIO_In = {18'h0, 18'h2A5A5};
        repeat (20) @(posedge HCLK);
        busRead(3'd0, R_IN, rd);
        checkOutput("in_ch0", 64'(rd), 64'h2A5A5);
        busRead(3'd0, R_STAT, rd);
        checkOutput("stat_ch0_disabled", 64'(rd), 64'h0);
        GPIO_In = '0;
        repeat (20) @(posedge HCLK);

`ifndef MFP_GPIO_DEBOUNCE_EN
        busWrite(3'd1, R_EN, 32'h1);
        busWrite(3'd1, R_POL, 32'h1);
        @(posedge HCLK); #1;
        GPIO_In[18] = 1'b1;
        repeat (3) @(posedge HCLK);
        #1 checkOutput("irq_before_4", 64'(GPIO_Irq), 64'h0);
        @(posedge HCLK);
        #1 checkOutput("irq_at_4", 64'(GPIO_Irq), 64'h1);
        busRead(3'd1, R_STAT, rd);
        checkOutput("stat_rise", 64'(rd), 64'h1);
        busWrite(3'd1, R_STAT, 32'h1);
        @(posedge HCLK);
        @(posedge HCLK);
        #1 checkOutput("irq_cleared", 64'(GPIO_Irq), 64'h0);
        busRead(3'd1, R_STAT, rd);
        checkOutput("stat_cleared", 64'(rd), 64'h0);

        busWrite(3'd1, R_POL, 32'h0);
        @(posedge HCLK); #1;
        GPIO_In[18] = 1'b0;
        repeat (5) @(posedge HCLK);
        busRead(3'd1, R_STAT, rd);
        checkOutput("stat_fall", 64'(rd), 64'h1);
        busWrite(3'd1, R_STAT, 32'h1);
        @(posedge HCLK); #1;
        busRead(3'd1, R_STAT, rd);
        checkOutput("stat_fall_cleared", 64'(rd), 64'h0);
        busWrite(3'd1, R_POL, 32'h1);
        @(posedge HCLK); #1;

        // Rising edge lands on the same edge that commits the W1C write.
        GPIO_In[18] = 1'b1;
        @(posedge HCLK); #1;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = regAddr(3'd1, R_STAT);
        @(posedge HCLK); #1;
        HWDATA = 32'h1;
        busIdle();
        @(posedge HCLK); #1;
        busRead(3'd1, R_STAT, rd);
        checkOutput("set_wins", 64'(rd), 64'h1);
        busWrite(3'd1, R_STAT, 32'h1);
        @(posedge HCLK); #1;
        busRead(3'd1, R_STAT, rd);
        checkOutput("set_wins_cleared", 64'(rd), 64'h0);
`else
        busWrite(3'd0, R_EN, 32'h1);
        busWrite(3'd0, R_POL, 32'h1);
        @(posedge HCLK); #1;
        GPIO_In[0] = 1'b1;
        repeat (3) @(posedge HCLK);
        #1 GPIO_In[0] = 1'b0;
        repeat (20) @(posedge HCLK);
        busRead(3'd0, R_IN, rd);
        checkOutput("glitch_in", 64'(rd), 64'h0);
        busRead(3'd0, R_STAT, rd);
        checkOutput("glitch_stat", 64'(rd), 64'h0);
        @(posedge HCLK); #1;
        GPIO_In[0] = 1'b1;
        repeat (12) @(posedge HCLK);
        busRead(3'd0, R_IN, rd);
        checkOutput("level_in", 64'(rd), 64'h1);
        busRead(3'd0, R_STAT, rd);
        checkOutput("level_stat", 64'(rd), 64'h1);
`endif

        // Asynchronous reset must clear outputs without waiting for a clock edge.
        @(posedge HCLK);
        #3 HRESETn = 1'b0;
        #1;
        checkOutput("async_reset_out", 64'(GPIO_Out), 64'h0);
        checkOutput("async_reset_oe", 64'(GPIO_Oe), 64'h0);
        checkOutput("async_reset_irq", 64'(GPIO_Irq), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
